// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register for the 5-stage MIPS datapath.
// Owns the PC, detects load-use hazards, applies EX branch redirects and counts stalls.
module if_id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstIF,
    input  logic        BranchTakenEX,
    input  logic [31:0] BranchTargetEX,
    input  logic        MemReadEX,
    input  logic [4:0]  RtEX,
    output logic [31:0] PCIF,
    output logic [31:0] InstID,
    output logic [31:0] PCPlus4ID,
    output logic        ValidID,
    output logic        HazardMUX,
    output logic [15:0] StallCount
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] pc_plus4;
    logic        stall;

    assign pc_plus4 = pc_q + 32'd4;

    // rt field is compared for every opcode; false stalls on I-type are tolerated.
    assign stall = MemReadEX & valid_q & (RtEX != 5'd0) &
                   ((RtEX == inst_q[25:21]) | (RtEX == inst_q[20:16]));

    always_comb begin
        pc_d        = pc_plus4;
        inst_d      = InstIF;
        pcp4_d      = pc_plus4;
        valid_d     = 1'b1;
        stall_cnt_d = stall_cnt_q;
        if (BranchTakenEX) begin
            pc_d    = BranchTargetEX;
            inst_d  = '0;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end else if (stall) begin
            pc_d    = pc_q;
            inst_d  = inst_q;
            pcp4_d  = pcp4_q;
            valid_d = valid_q;
            if (stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            inst_q      <= '0;
            pcp4_q      <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PCIF       = pc_q;
    assign InstID     = inst_q;
    assign PCPlus4ID  = pcp4_q;
    assign ValidID    = valid_q;
    assign HazardMUX  = stall | BranchTakenEX;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: fetch, load-use stall, branch flush, wrap, saturation, async reset.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstIF;
    logic        BranchTakenEX;
    logic [31:0] BranchTargetEX;
    logic        MemReadEX;
    logic [4:0]  RtEX;
    logic [31:0] PCIF;
    logic [31:0] InstID;
    logic [31:0] PCPlus4ID;
    logic        ValidID;
    logic        HazardMUX;
    logic [15:0] StallCount;

    int unsigned total  = 0;
    int unsigned passed = 0;

    if_id_stage dut (
        .clk            (clk),
        .rst            (rst),
        .InstIF         (InstIF),
        .BranchTakenEX  (BranchTakenEX),
        .BranchTargetEX (BranchTargetEX),
        .MemReadEX      (MemReadEX),
        .RtEX           (RtEX),
        .PCIF           (PCIF),
        .InstID         (InstID),
        .PCPlus4ID      (PCPlus4ID),
        .ValidID        (ValidID),
        .HazardMUX      (HazardMUX),
        .StallCount     (StallCount)
    );

    always #5 clk = ~clk;

    // Instruction memory; unlisted addresses return a tag with zero rs/rt fields.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem = 32'h2008_0005;
            32'h0000_0004: imem = 32'h2009_0007;
            32'h0000_0008: imem = 32'h0109_5020;
            32'h0000_0040: imem = 32'h8C0B_0000;
            default:       imem = {16'hA000, a[15:0]};
        endcase
    endfunction

    always_comb InstIF = imem(PCIF);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; BranchTakenEX = 1'b0; BranchTargetEX = '0; MemReadEX = 1'b0; RtEX = '0;
        #2;
        check("rst_pc", PCIF, 32'h0);
        check("rst_inst", InstID, 32'h0);
        check("rst_pcp4", PCPlus4ID, 32'h0);
        check("rst_valid", {31'b0, ValidID}, 32'h0);
        check("rst_cnt", {16'b0, StallCount}, 32'h0);
        check("rst_haz", {31'b0, HazardMUX}, 32'h0);
        #5 rst = 1'b0;

        tick;
        check("f1_inst", InstID, 32'h2008_0005);
        check("f1_pcp4", PCPlus4ID, 32'h4);
        check("f1_pc", PCIF, 32'h4);
        check("f1_valid", {31'b0, ValidID}, 32'h1);
        tick;
        check("f2_inst", InstID, 32'h2009_0007);
        check("f2_pcp4", PCPlus4ID, 32'h8);
        check("f2_pc", PCIF, 32'h8);
        tick;
        check("f3_inst", InstID, 32'h0109_5020);

        // load-use on $9 (rt of add $10,$8,$9)
        MemReadEX = 1'b1; RtEX = 5'd9; #1;
        check("lu_haz", {31'b0, HazardMUX}, 32'h1);
        tick;
        check("lu_pc", PCIF, 32'hC);
        check("lu_inst", InstID, 32'h0109_5020);
        check("lu_pcp4", PCPlus4ID, 32'hC);
        check("lu_cnt", {16'b0, StallCount}, 32'h1);
        MemReadEX = 1'b0; #1;
        check("lu_drop", {31'b0, HazardMUX}, 32'h0);
        MemReadEX = 1'b1; RtEX = 5'd0; #1;
        check("r0_haz", {31'b0, HazardMUX}, 32'h0);
        tick;
        check("r0_inst", InstID, 32'hA000_000C);
        check("r0_pc", PCIF, 32'h10);
        check("r0_cnt", {16'b0, StallCount}, 32'h1);
        MemReadEX = 1'b0;

        BranchTakenEX = 1'b1; BranchTargetEX = 32'h40; #1;
        check("br_haz", {31'b0, HazardMUX}, 32'h1);
        tick;
        check("br_pc", PCIF, 32'h40);
        check("br_inst", InstID, 32'h0);
        check("br_valid", {31'b0, ValidID}, 32'h0);
        BranchTakenEX = 1'b0; #1;
        check("br_haz_off", {31'b0, HazardMUX}, 32'h0);
        tick;
        check("bt_inst", InstID, 32'h8C0B_0000);
        check("bt_pcp4", PCPlus4ID, 32'h44);
        check("bt_valid", {31'b0, ValidID}, 32'h1);

        // stall (rt=$11) and branch together: branch wins
        MemReadEX = 1'b1; RtEX = 5'd11; BranchTakenEX = 1'b1; BranchTargetEX = 32'h8; #1;
        check("bs_haz", {31'b0, HazardMUX}, 32'h1);
        tick;
        check("bs_pc", PCIF, 32'h8);
        check("bs_inst", InstID, 32'h0);
        check("bs_valid", {31'b0, ValidID}, 32'h0);
        check("bs_cnt", {16'b0, StallCount}, 32'h1);
        MemReadEX = 1'b0; RtEX = '0; BranchTakenEX = 1'b0;
        tick;
        check("bs_next", InstID, 32'h0109_5020);

        BranchTakenEX = 1'b1; BranchTargetEX = 32'hFFFF_FFFC;
        tick;
        check("wr_pc0", PCIF, 32'hFFFF_FFFC);
        BranchTakenEX = 1'b0;
        tick;
        check("wr_pc", PCIF, 32'h0);
        check("wr_pcp4", PCPlus4ID, 32'h0);
        check("wr_inst", InstID, 32'hA000_FFFC);
        tick; tick; tick;
        check("sat_pre", InstID, 32'h0109_5020);

        // hold a stall on rs=$8 long enough to saturate the counter
        MemReadEX = 1'b1; RtEX = 5'd8;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        check("sat_cnt", {16'b0, StallCount}, 32'hFFFF);
        check("sat_pc", PCIF, 32'hC);
        tick; tick;
        check("sat_hold", {16'b0, StallCount}, 32'hFFFF);

        #2 rst = 1'b1; #1;
        check("ar_pc", PCIF, 32'h0);
        check("ar_inst", InstID, 32'h0);
        check("ar_valid", {31'b0, ValidID}, 32'h0);
        check("ar_cnt", {16'b0, StallCount}, 32'h0);
        check("ar_haz", {31'b0, HazardMUX}, 32'h0);
        MemReadEX = 1'b0; RtEX = '0;
        #1 rst = 1'b0;
        tick;
        check("ar_f1", InstID, 32'h2008_0005);
        check("ar_f1pc", PCIF, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch stage plus IF/ID pipeline register for the 5-stage pipelined MIPS datapath, directly upstream of the ID/EX register. It owns the PC, drives the combinational instruction-memory address, and captures the fetched instruction and PC+4 for decode. It also contains load-use hazard detection. On a hazard it stalls the PC and the IF/ID register and raises HazardMUX, which makes the ID/EX register load a bubble. It applies branch redirects resolved in EX, and keeps a saturating stall counter for performance measurement.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register specifiers).
- clk  input  1  sole clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- InstIF  input  32  instruction word returned combinationally by instruction memory for PCIF.
- BranchTakenEX  input  1  branch in EX resolved taken this cycle.
- BranchTargetEX  input  32  redirect address; valid when BranchTakenEX=1.
- MemReadEX  input  1  instruction in EX is a load.
- RtEX  input  5  destination register of the instruction in EX.
- PCIF  output  32  current PC, instruction-memory address.
- InstID  output  32  instruction held in the IF/ID register.
- PCPlus4ID  output  32  PC+4 of the instruction in InstID.
- ValidID  output  1  InstID holds a real instruction, not a flush bubble.
- HazardMUX  output  1  bubble request to ID/EX; combinational.
- StallCount  output  16  number of load-use stall cycles since reset, saturating.

## Operation
- Next-PC priority: BranchTakenEX, then stall, then sequential.
  - BranchTakenEX=1: PC <= BranchTargetEX.
  - Otherwise, stall=1: PC holds.
  - Otherwise: PC <= PC+4.
- PC+4 is computed modulo 2^32: 0xFFFFFFFC+4 = 0x00000000. BranchTargetEX is used unmodified; no alignment forcing.
- Load-use stall is combinational: stall = MemReadEX & ValidID & (RtEX != 0) & (RtEX == InstID[25:21] | RtEX == InstID[20:16]).
  - The rt field is compared for every opcode. False stalls on I-type instructions are accepted.
- IF/ID register update, same priority order:
  - BranchTakenEX=1: flush. InstID <= 0, PCPlus4ID <= 0, ValidID <= 0.
  - Otherwise, stall=1: hold all three registers.
  - Otherwise: InstID <= InstIF, PCPlus4ID <= PCIF+4, ValidID <= 1.
- HazardMUX = stall | BranchTakenEX.
  - On a branch, this kills the wrong-path instruction currently in ID.
  - The instruction in EX is the branch itself. Squashing any younger instruction is the downstream stage's concern.
- StallCount increments by 1 on every posedge where stall=1 and BranchTakenEX=0. It saturates at 0xFFFF and never wraps.
- Flush bubble: InstID = 0x00000000 decodes as sll $0,$0,0, which is a NOP. With ValidID=0, hazard detection ignores it.

## Timing
- Reset values while rst=1, asynchronously:
  - PCIF = 0, InstID = 0, PCPlus4ID = 0, ValidID = 0, StallCount = 0.
  - HazardMUX = MemReadEX-driven term only, which is 0 because ValidID=0.
- First fetch: the first posedge after rst deasserts captures Mem[0] into InstID, and PCIF becomes 4.
- Latency: an instruction presented on InstIF appears on InstID 1 cycle later, absent stall or flush.
- A load-use stall lasts exactly 1 cycle. After the hold, the load has moved to MEM, so MemReadEX or RtEX no longer match and the stall drops.
- Branch redirect: the cycle after BranchTakenEX, PCIF = BranchTargetEX and ValidID = 0. The target instruction reaches ID one cycle later.
- Simultaneous stall and branch: the branch wins. PC redirects, IF/ID flushes, and StallCount does not increment.
- rst asserted mid-stall or mid-redirect: all state clears immediately, and the pending redirect is lost.
- HazardMUX and PCIF change only from registered state or from same-cycle EX inputs. There is no path from InstIF to any output.

## Test plan
- Reset/fetch: release rst with imem[0]=0x20080005, imem[4]=0x20090007 -> PCIF goes 0, 4, 8. InstID = 0x20080005 with PCPlus4ID = 4, then 0x20090007 with PCPlus4ID = 8. ValidID = 1 from the first edge.
- Load-use: InstID = 0x01095020 (add $10,$8,$9), MemReadEX = 1, RtEX = 9.
  - HazardMUX = 1; PCIF, InstID and PCPlus4ID hold for 1 cycle; StallCount goes 0 -> 1.
  - Repeat with RtEX = 0 -> no stall.
- Branch: BranchTakenEX = 1, BranchTargetEX = 0x00000040 -> HazardMUX = 1 that cycle. Next cycle PCIF = 0x40, InstID = 0, ValidID = 0. The cycle after, InstID = imem[0x40].
- Branch with stall in the same cycle: MemReadEX = 1 with matching RtEX and BranchTakenEX = 1 -> PCIF = target, IF/ID flushed, StallCount unchanged.
- Wrap and saturation:
  - Redirect to 0xFFFFFFFC -> next PCIF = 0, PCPlus4ID = 0.
  - Hold a stall for 70000 cycles (force-held inputs) -> StallCount = 0xFFFF and stays there.
- Async reset: assert rst mid-cycle during a stall -> all outputs clear before the next edge, with StallCount = 0.
